sramlike_arbiter_nx1: RTL and testbench

- Parametrised N-master to 1-slave SRAM-like arbiter. Generalises the fixed two-way data-path bridging in the CPU top.
- Merges several SRAM-like request channels onto one SRAM-like slave, for example I-cache, D-cache and uncached paths onto the single AXI interface port.
- Round-robin fair arbitration with request locking until addr_ok.
- In-order response routing through an outstanding-transaction ID FIFO, allowing pipelined requests.

---
 rtl/sramlike_arbiter_nx1_if.sv | 34 +++
 rtl/sramlike_arbiter_nx1.sv | 116 +++++++++++
 tb/tb_sramlike_arbiter_nx1.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sramlike_arbiter_nx1_if.sv
// Bundle of the N SRAM-like master channels and the single SRAM-like slave channel.
// The master modport is the arbiter's view; the slave modport is the mirror used by the environment.
interface sramlike_arbiter_nx1_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_wr;
    logic [2*NUM_MASTERS-1:0]      m_size;
    logic [ADDR_W*NUM_MASTERS-1:0] m_addr;
    logic [DATA_W*NUM_MASTERS-1:0] m_wdata;
    logic [DATA_W-1:0]             m_rdata;
    logic [NUM_MASTERS-1:0]        m_addr_ok;
    logic [NUM_MASTERS-1:0]        m_data_ok;
    logic                          s_req;
    logic                          s_wr;
    logic [1:0]                    s_size;
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_W-1:0]             s_wdata;
    logic [DATA_W-1:0]             s_rdata;
    logic                          s_addr_ok;
    logic                          s_data_ok;

    modport master (
        input  m_req, m_wr, m_size, m_addr, m_wdata, s_rdata, s_addr_ok, s_data_ok,
        output m_rdata, m_addr_ok, m_data_ok, s_req, s_wr, s_size, s_addr, s_wdata
    );

    modport slave (
        output m_req, m_wr, m_size, m_addr, m_wdata, s_rdata, s_addr_ok, s_data_ok,
        input  m_rdata, m_addr_ok, m_data_ok, s_req, s_wr, s_size, s_addr, s_wdata
    );
endinterface

// File: rtl/sramlike_arbiter_nx1.sv
// N-to-1 SRAM-like arbiter: round-robin grant locked until addr_ok, with an ID FIFO
// that routes in-order responses back to the master that issued each request.
module sramlike_arbiter_nx1 #(
    parameter int NUM_MASTERS     = 3,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    sramlike_arbiter_nx1_if.master            bus,
    output logic [$clog2(MAX_OUTSTANDING):0]  o_outstanding,
    output logic                              o_err_spurious
);
    localparam int IDW   = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0]   r_rr_ptr;
    logic             r_lock_valid;
    logic [IDW-1:0]   r_lock_id;
    logic [IDW-1:0]   r_fifo [2**PTR_W];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err_spurious;

    logic             w_grant_valid;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_sel;
    logic [IDW:0]     w_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_s_req;
    logic             w_push;
    logic             w_pop;
    logic [IDW-1:0]   w_rr_next;
    logic [NUM_MASTERS-1:0] w_addr_ok;
    logic [NUM_MASTERS-1:0] w_data_ok;

    // A locked grant holds even if the master drops m_req; the lock then clears next cycle.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = '0;
        if (r_lock_valid) begin
            w_grant_valid = 1'b1;
            w_grant       = r_lock_id;
        end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_idx >= (IDW+1)'(NUM_MASTERS))
                    w_idx = w_idx - (IDW+1)'(NUM_MASTERS);
                if (!w_grant_valid && bus.m_req[w_idx[IDW-1:0]]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = w_idx[IDW-1:0];
                end
            end
        end
    end

    assign w_sel     = w_grant_valid ? w_grant : '0;
    assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty   = (r_count == '0);
    assign w_s_req   = !rst && w_grant_valid && bus.m_req[w_sel] && !w_full;
    assign w_push    = w_s_req && bus.s_addr_ok;
    assign w_pop     = !rst && bus.s_data_ok && !w_empty;
    assign w_rr_next = (w_sel == IDW'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_addr_ok        = '0;
        w_data_ok        = '0;
        w_addr_ok[w_sel] = w_push;
        w_data_ok[r_fifo[r_rd_ptr]] = w_pop;
    end

    assign bus.s_req     = w_s_req;
    assign bus.s_wr      = bus.m_wr[w_sel];
    assign bus.s_size    = bus.m_size[2*w_sel +: 2];
    assign bus.s_addr    = bus.m_addr[ADDR_W*w_sel +: ADDR_W];
    assign bus.s_wdata   = bus.m_wdata[DATA_W*w_sel +: DATA_W];
    assign bus.m_rdata   = bus.s_rdata;
    assign bus.m_addr_ok = w_addr_ok;
    assign bus.m_data_ok = w_data_ok;
    assign o_outstanding = r_count;
    assign o_err_spurious = r_err_spurious;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_lock_valid   <= 1'b0;
            r_lock_id      <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_lock_valid     <= 1'b0;
                r_rr_ptr         <= w_rr_next;
            end else if (w_s_req) begin
                r_lock_valid <= 1'b1;
                r_lock_id    <= w_sel;
            end else if (r_lock_valid && !bus.m_req[r_lock_id]) begin
                r_lock_valid <= 1'b0;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (bus.s_data_ok && w_empty)
                r_err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sramlike_arbiter_nx1.sv
// Directed bench for sramlike_arbiter_nx1 (3 masters, 4 outstanding): vector table plus
// hand-written lock, lock-drop and reset/spurious sequences.
module tb_sramlike_arbiter_nx1;
    localparam int N = 3;
    localparam logic [31:0] ADDR [N] = '{32'h1000_0000, 32'h1FC0_0000, 32'h2000_0000};
    localparam logic [31:0] WDAT [N] = '{32'h0000_AAAA, 32'h1111_BBBB, 32'h2222_CCCC};
    localparam logic [N-1:0] WR_BITS = 3'b101;
    localparam logic [2*N-1:0] SIZE_BITS = 6'b10_01_00;

    logic       clk;
    logic       rst;
    logic [2:0] outstanding;
    logic       err_spurious;
    int         total;
    int         bad;
    logic [2:0] exp_q[$];

    sramlike_arbiter_nx1_if #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32)) bus ();

    sramlike_arbiter_nx1 #(
        .NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .o_outstanding  (outstanding),
        .o_err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_sreq;
        logic [2:0]  exp_aok;
        logic [2:0]  exp_dok;
        logic [2:0]  exp_cnt;
        int          exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] req, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic sreq,
                                input logic [2:0] eaok, input logic [2:0] edok,
                                input logic [2:0] cnt, input int sel);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp_sreq = sreq; v.exp_aok = eaok; v.exp_dok = edok; v.exp_cnt = cnt; v.exp_sel = sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        bus.m_req     = req;
        bus.s_addr_ok = aok;
        bus.s_data_ok = dok;
        bus.s_rdata   = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mux(input string name, input int sel);
        chk({name, ".s_addr"},  bus.s_addr,  ADDR[sel]);
        chk({name, ".s_wdata"}, bus.s_wdata, WDAT[sel]);
        chk({name, ".s_wr"},    bus.s_wr,    WR_BITS[sel]);
        chk({name, ".s_size"},  bus.s_size,  SIZE_BITS[2*sel +: 2]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.m_wr    = WR_BITS;
        bus.m_size  = SIZE_BITS;
        bus.m_addr  = {ADDR[2], ADDR[1], ADDR[0]};
        bus.m_wdata = {WDAT[2], WDAT[1], WDAT[0]};

        // Reset idle
        vecs.push_back(mk(3'b000, 0, 0, 32'h0, 0, 3'b000, 3'b000, 3'd0, 0));
        // Round-robin with one response per cycle
        vecs.push_back(mk(3'b111, 1, 0, 32'h0,       1, 3'b001, 3'b000, 3'd0, 0));
        vecs.push_back(mk(3'b111, 1, 1, 32'h0000_0010, 1, 3'b010, 3'b001, 3'd1, 1));
        vecs.push_back(mk(3'b111, 1, 1, 32'h0000_0020, 1, 3'b100, 3'b010, 3'd1, 2));
        vecs.push_back(mk(3'b111, 1, 1, 32'h0000_0030, 1, 3'b001, 3'b100, 3'd1, 0));
        vecs.push_back(mk(3'b111, 1, 1, 32'h0000_0040, 1, 3'b010, 3'b001, 3'd1, 1));
        vecs.push_back(mk(3'b111, 1, 1, 32'h0000_0050, 1, 3'b100, 3'b010, 3'd1, 2));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0000_0060, 0, 3'b000, 3'b100, 3'd1, 0));
        // Single master, pipelined read
        vecs.push_back(mk(3'b010, 1, 0, 32'h0,         1, 3'b010, 3'b000, 3'd0, 1));
        vecs.push_back(mk(3'b000, 0, 1, 32'hDEAD_BEEF, 0, 3'b000, 3'b010, 3'd1, 0));
        vecs.push_back(mk(3'b000, 0, 0, 32'h0,         0, 3'b000, 3'b000, 3'd0, 0));
        // Fill to four outstanding, then full behaviour
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd0, 0));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd1, 0));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd2, 0));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd3, 0));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 0, 3'b000, 3'b000, 3'd4, 0));
        vecs.push_back(mk(3'b001, 1, 1, 32'h0, 0, 3'b000, 3'b001, 3'd4, 0));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd3, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b001, 3'd4, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b001, 3'd3, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b001, 3'd2, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b001, 3'd1, 0));
        // Ordering: accept m1, m0, m2 then respond in that order
        vecs.push_back(mk(3'b010, 1, 0, 32'h0, 1, 3'b010, 3'b000, 3'd0, 1));
        vecs.push_back(mk(3'b001, 1, 0, 32'h0, 1, 3'b001, 3'b000, 3'd1, 0));
        vecs.push_back(mk(3'b100, 1, 0, 32'h0, 1, 3'b100, 3'b000, 3'd2, 2));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b010, 3'd3, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b001, 3'd2, 0));
        vecs.push_back(mk(3'b000, 0, 1, 32'h0, 0, 3'b000, 3'b100, 3'd1, 0));
        vecs.push_back(mk(3'b000, 0, 0, 32'h0, 0, 3'b000, 3'b000, 3'd0, 0));

        // Reset: outputs forced low even with request, addr_ok and data_ok high
        rst = 1'b1;
        drive(3'b111, 1'b1, 1'b1, 32'h0);
        step();
        @(negedge clk);
        chk("rst.s_req", bus.s_req, 1'b0);
        chk("rst.m_addr_ok", bus.m_addr_ok, 3'b000);
        chk("rst.m_data_ok", bus.m_data_ok, 3'b000);
        step();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d.s_req", i),     bus.s_req,     vecs[i].exp_sreq);
            chk($sformatf("v%0d.m_addr_ok", i), bus.m_addr_ok, vecs[i].exp_aok);
            chk($sformatf("v%0d.m_data_ok", i), bus.m_data_ok, vecs[i].exp_dok);
            chk($sformatf("v%0d.outstanding", i), outstanding, vecs[i].exp_cnt);
            chk($sformatf("v%0d.m_rdata", i),   bus.m_rdata,   vecs[i].rdata);
            chk($sformatf("v%0d.err", i),       err_spurious,  1'b0);
            chk_mux($sformatf("v%0d", i), vecs[i].exp_sel);
            step();
        end

        // Lock: master 2 stalled three cycles, master 0 joins on the second cycle
        for (int c = 1; c <= 4; c++) begin
            drive((c == 1) ? 3'b100 : 3'b101, (c == 4), 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("lock%0d.s_req", c), bus.s_req, 1'b1);
            chk_mux($sformatf("lock%0d", c), 2);
            chk($sformatf("lock%0d.m_addr_ok", c), bus.m_addr_ok, (c == 4) ? 3'b100 : 3'b000);
            step();
        end
        exp_q.push_back(3'b100);
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("lock5.m_addr_ok", bus.m_addr_ok, 3'b001);
        chk_mux("lock5", 0);
        chk("lock5.outstanding", outstanding, 3'd1);
        exp_q.push_back(3'b001);
        step();
        drive(3'b000, 1'b0, 1'b1, 32'h0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            chk("drain.m_data_ok", bus.m_data_ok, exp_q.pop_front());
            step();
        end

        // Locked master withdraws: lock drops, rr pointer (1) is not advanced
        drive(3'b010, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("drop1.s_req", bus.s_req, 1'b1);
        chk_mux("drop1", 1);
        step();
        drive(3'b100, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("drop2.s_req", bus.s_req, 1'b0);
        chk("drop2.m_addr_ok", bus.m_addr_ok, 3'b000);
        step();
        drive(3'b101, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("drop3.m_addr_ok", bus.m_addr_ok, 3'b100);
        chk_mux("drop3", 2);
        step();
        drive(3'b000, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("drop4.m_data_ok", bus.m_data_ok, 3'b100);
        step();

        // Reset with two outstanding, then a now-spurious response
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        step();
        drive(3'b010, 1'b1, 1'b0, 32'h0);
        step();
        rst = 1'b1;
        drive(3'b111, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        chk("sp.pre_rst_outstanding", outstanding, 3'd2);
        chk("sp.rst_s_req", bus.s_req, 1'b0);
        chk("sp.rst_m_data_ok", bus.m_data_ok, 3'b000);
        step();
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("sp.outstanding", outstanding, 3'd0);
        chk("sp.m_data_ok", bus.m_data_ok, 3'b000);
        chk("sp.err_before", err_spurious, 1'b0);
        step();
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("sp.err_after", err_spurious, 1'b1);
        chk("sp.outstanding_after", outstanding, 3'd0);
        step();
        @(negedge clk);
        chk("sp.err_sticky", err_spurious, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
